// File: rtl/spi_wb_bridge.sv
// SPI-byte-stream to Wishbone B4 pipelined master bridge.
// Decodes read/write frames with a 20-bit address and issues single-beat bus cycles.
module spi_wb_bridge #(
  parameter int unsigned WB_ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH    = 8
) (
  input  logic                     wb_clock_i,
  input  logic                     wb_reset_i,
  input  logic                     spi_cs_i,
  input  logic                     rx_valid_i,
  input  logic [DATA_WIDTH-1:0]    rx_data_i,
  output logic [DATA_WIDTH-1:0]    tx_data_o,
  output logic                     tx_valid_o,
  output logic                     busy_o,
  output logic                     overflow_o,
  output logic [WB_ADDR_WIDTH-1:0] wb_addr_o,
  output logic [DATA_WIDTH-1:0]    wb_data_o,
  input  logic [DATA_WIDTH-1:0]    wb_data_i,
  output logic                     wb_we_o,
  output logic                     wb_cycle_o,
  output logic                     wb_strobe_o,
  input  logic                     wb_stall_i,
  input  logic                     wb_ack_i
);

  typedef enum logic [2:0] {
    S_CMD, S_ADDR_HI, S_ADDR_LO, S_DATA, S_WB_REQ, S_WB_WAIT, S_RDY, S_IGNORE
  } state_e;

  state_e                   state_q;
  logic                     cs_q, end_q, we_q, cyc_q, stb_q, tx_valid_q, overflow_q;
  logic [WB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, tx_data_q;
  logic                     cs_rise, cs_fall, in_bus, done;

  assign cs_rise = spi_cs_i & ~cs_q;
  assign cs_fall = ~spi_cs_i & cs_q;
  assign in_bus  = (state_q == S_WB_REQ) || (state_q == S_WB_WAIT);
  // Completion: ack in WAIT, or ack in the same cycle the request is accepted.
  assign done    = wb_ack_i && ((state_q == S_WB_WAIT) || (state_q == S_WB_REQ && !wb_stall_i));
  assign addr_d  = addr_q + WB_ADDR_WIDTH'(1);

  always_ff @(posedge wb_clock_i) begin
    if (!wb_reset_i) begin
      state_q    <= S_CMD;
      cs_q       <= 1'b0;
      end_q      <= 1'b0;
      we_q       <= 1'b0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      tx_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      tx_data_q  <= '0;
    end else begin
      cs_q       <= spi_cs_i;
      tx_valid_q <= 1'b0;
      if (cs_rise) overflow_q <= 1'b0;
      if (rx_valid_i && in_bus) overflow_q <= 1'b1;
      if (cs_fall && in_bus) end_q <= 1'b1;

      if (done) begin
        cyc_q  <= 1'b0;
        stb_q  <= 1'b0;
        addr_q <= addr_d;
        if (!we_q) begin
          tx_data_q  <= wb_data_i;
          tx_valid_q <= 1'b1;
        end
        // A frame that ended while the bus was busy resumes at the command byte.
        if (end_q || !spi_cs_i) begin
          state_q <= S_CMD;
          end_q   <= 1'b0;
        end else begin
          state_q <= we_q ? S_DATA : S_RDY;
        end
      end else begin
        case (state_q)
          S_WB_REQ: begin
            if (!wb_stall_i) begin
              stb_q   <= 1'b0;
              state_q <= S_WB_WAIT;
            end
          end
          S_WB_WAIT: begin
          end
          default: begin
            if (cs_fall || cs_rise) begin
              state_q <= S_CMD;
              if (cs_rise) begin
                addr_q <= '0;
                we_q   <= 1'b0;
              end
            end else if (rx_valid_i) begin
              if (state_q == S_CMD) begin
                we_q          <= ~rx_data_i[7];
                addr_q[19:16] <= rx_data_i[3:0];
                state_q       <= (rx_data_i[6:4] != 3'b000) ? S_IGNORE : S_ADDR_HI;
              end else if (state_q == S_ADDR_HI) begin
                addr_q[15:8] <= rx_data_i;
                state_q      <= S_ADDR_LO;
              end else if (state_q == S_ADDR_LO) begin
                addr_q[7:0] <= rx_data_i;
                if (we_q) begin
                  state_q <= S_DATA;
                end else begin
                  state_q <= S_WB_REQ;
                  cyc_q   <= 1'b1;
                  stb_q   <= 1'b1;
                end
              end else if (state_q == S_DATA) begin
                wdata_q <= rx_data_i;
                state_q <= S_WB_REQ;
                cyc_q   <= 1'b1;
                stb_q   <= 1'b1;
              end else if (state_q == S_RDY) begin
                state_q <= S_WB_REQ;
                cyc_q   <= 1'b1;
                stb_q   <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

  assign tx_data_o   = tx_data_q;
  assign tx_valid_o  = tx_valid_q;
  assign busy_o      = cyc_q;
  assign overflow_o  = overflow_q;
  assign wb_addr_o   = addr_q;
  assign wb_data_o   = wdata_q;
  assign wb_we_o     = we_q;
  assign wb_cycle_o  = cyc_q;
  assign wb_strobe_o = stb_q;

endmodule

// File: tb/tb_spi_wb_bridge.sv
// Directed bench for spi_wb_bridge with a small Wishbone slave model and request log.
module tb_spi_wb_bridge;

  typedef struct packed {
    logic        we;
    logic [19:0] addr;
    logic [7:0]  data;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [7:0]  tx_data;
  logic        tx_valid, busy, overflow;
  logic [19:0] wb_addr;
  logic [7:0]  wb_dout;
  logic [7:0]  wb_din = 8'h00;
  logic        wb_we, wb_cyc, wb_stb;
  logic        wb_stall = 1'b0;
  logic        wb_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  int   stall_cfg = 0, ack_delay = 0, stall_cnt = 0, ack_wait = 0;
  int   stb_cnt = 0, tx_cnt = 0, cyc_cnt = 0;
  bit   ack_same = 1'b0, ack_pend = 1'b0;
  logic [7:0] rd_data = 8'h00;
  logic [7:0] tx_last = 8'h00;
  req_t req_q[$];

  always #5 clk = ~clk;

  spi_wb_bridge dut (
    .wb_clock_i (clk),
    .wb_reset_i (rst_n),
    .spi_cs_i   (cs),
    .rx_valid_i (rx_valid),
    .rx_data_i  (rx_data),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .busy_o     (busy),
    .overflow_o (overflow),
    .wb_addr_o  (wb_addr),
    .wb_data_o  (wb_dout),
    .wb_data_i  (wb_din),
    .wb_we_o    (wb_we),
    .wb_cycle_o (wb_cyc),
    .wb_strobe_o(wb_stb),
    .wb_stall_i (wb_stall),
    .wb_ack_i   (wb_ack)
  );

  // Slave model and monitors; decisions made on the falling edge for the next rising edge.
  always @(negedge clk) begin
    req_t r;
    wb_ack   = 1'b0;
    wb_stall = 1'b0;
    if (!rst_n) begin
      ack_pend  = 1'b0;
      stall_cnt = 0;
    end else if (ack_pend) begin
      if (ack_wait == 0) begin
        wb_ack   = 1'b1;
        wb_din   = rd_data;
        ack_pend = 1'b0;
      end else begin
        ack_wait--;
      end
    end else if (wb_cyc && wb_stb) begin
      stb_cnt++;
      if (stall_cnt < stall_cfg) begin
        wb_stall = 1'b1;
        stall_cnt++;
      end else begin
        stall_cnt = 0;
        r.we = wb_we;
        r.addr = wb_addr;
        r.data = wb_dout;
        req_q.push_back(r);
        if (ack_same) begin
          wb_ack = 1'b1;
          wb_din = rd_data;
        end else begin
          ack_pend = 1'b1;
          ack_wait = ack_delay;
        end
      end
    end
    if (tx_valid) begin
      tx_cnt++;
      tx_last = tx_data;
    end
    if (wb_cyc) cyc_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_req(input string tag, input logic we, input logic [19:0] addr,
                           input logic [7:0] data, input bit chk_data);
    req_t r;
    check({tag, "_count"}, 32'(req_q.size()), 32'd1);
    if (req_q.size() > 0) begin
      r = req_q.pop_front();
      check({tag, "_we"}, 32'(r.we), 32'(we));
      check({tag, "_addr"}, 32'(r.addr), 32'(addr));
      if (chk_data) check({tag, "_data"}, 32'(r.data), 32'(data));
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (wb_cyc && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle_timeout"}, 32'(n < 200), 32'd1);
    @(negedge clk);
  endtask

  task automatic cs_set(input logic v);
    @(negedge clk);
    cs = v;
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cyc", 32'(wb_cyc), 32'd0);
    check("rst_stb", 32'(wb_stb), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_addr", 32'(wb_addr), 32'h0);
    rst_n = 1'b1;

    // Write burst
    cs_set(1'b1);
    send_byte(8'h01); send_byte(8'h23); send_byte(8'h45); send_byte(8'hAA);
    check("wr_stb_latency", 32'(wb_stb), 32'd1);
    check("wr_addr_out", 32'(wb_addr), 32'h12345);
    check("wr_we_out", 32'(wb_we), 32'd1);
    wait_idle("wr0");
    check_req("wr0", 1'b1, 20'h12345, 8'hAA, 1'b1);
    send_byte(8'hBB);
    wait_idle("wr1");
    check_req("wr1", 1'b1, 20'h12346, 8'hBB, 1'b1);
    check("wr_overflow", 32'(overflow), 32'd0);
    cs_set(1'b0);

    // Read with stall
    stall_cfg = 3; rd_data = 8'h5A; stb_cnt = 0; tx_cnt = 0;
    cs_set(1'b1);
    send_byte(8'h80); send_byte(8'h00); send_byte(8'h10);
    check("rd_stb_latency", 32'(wb_stb), 32'd1);
    wait_idle("rd0");
    check("rd_stb_cycles", 32'(stb_cnt), 32'd4);
    check_req("rd0", 1'b0, 20'h00010, 8'h00, 1'b0);
    check("rd_tx_data", 32'(tx_data), 32'h5A);
    check("rd_tx_pulses", 32'(tx_cnt), 32'd1);
    check("rd_tx_valid_low", 32'(tx_valid), 32'd0);
    stall_cfg = 0; rd_data = 8'hC3;
    send_byte(8'h00);
    wait_idle("rd1");
    check_req("rd1", 1'b0, 20'h00011, 8'h00, 1'b0);
    check("rd1_tx_last", 32'(tx_last), 32'hC3);
    check("rd1_tx_pulses", 32'(tx_cnt), 32'd2);
    cs_set(1'b0);

    // Address wrap
    rd_data = 8'h11; tx_cnt = 0;
    cs_set(1'b1);
    send_byte(8'h8F); send_byte(8'hFF); send_byte(8'hFF);
    wait_idle("wrap0");
    check_req("wrap0", 1'b0, 20'hFFFFF, 8'h00, 1'b0);
    send_byte(8'h00);
    wait_idle("wrap1");
    check_req("wrap1", 1'b0, 20'h00000, 8'h00, 1'b0);
    send_byte(8'h00);
    wait_idle("wrap2");
    check_req("wrap2", 1'b0, 20'h00001, 8'h00, 1'b0);
    check("wrap_addr_next", 32'(wb_addr), 32'h00002);
    check("wrap_tx_pulses", 32'(tx_cnt), 32'd3);
    cs_set(1'b0);

    // Overflow while waiting for a slow ack
    ack_delay = 10;
    cs_set(1'b1);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h20); send_byte(8'h55);
    repeat (2) @(negedge clk);
    send_byte(8'h99);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_busy", 32'(busy), 32'd1);
    wait_idle("ovf");
    check_req("ovf", 1'b1, 20'h00020, 8'h55, 1'b1);
    check("ovf_wdata_kept", 32'(wb_dout), 32'h55);
    repeat (4) @(negedge clk);
    check("ovf_no_extra_req", 32'(req_q.size()), 32'd0);
    cs_set(1'b0);
    check("ovf_sticky", 32'(overflow), 32'd1);
    cs_set(1'b1);
    check("ovf_cleared", 32'(overflow), 32'd0);
    cs_set(1'b0);

    // CS drop during WB_WAIT, then a fresh frame with same-cycle ack
    cs_set(1'b1);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h30); send_byte(8'h66);
    repeat (2) @(negedge clk);
    cs = 1'b0;
    repeat (3) @(negedge clk);
    check("csdrop_cyc_held", 32'(wb_cyc), 32'd1);
    wait_idle("csdrop");
    check_req("csdrop", 1'b1, 20'h00030, 8'h66, 1'b1);
    ack_delay = 0; ack_same = 1'b1;
    cs_set(1'b1);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'h77);
    check("newframe_stb", 32'(wb_stb), 32'd1);
    @(negedge clk);
    check("same_ack_done", 32'(wb_cyc), 32'd0);
    check_req("newframe", 1'b1, 20'h00001, 8'h77, 1'b1);
    check("newframe_addr_inc", 32'(wb_addr), 32'h00002);
    ack_same = 1'b0;
    cs_set(1'b0);

    // Reset during a stalled request
    stall_cfg = 50;
    cs_set(1'b1);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h40); send_byte(8'h88);
    check("rstmid_stb_before", 32'(wb_stb), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstmid_cyc", 32'(wb_cyc), 32'd0);
    check("rstmid_stb", 32'(wb_stb), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_addr", 32'(wb_addr), 32'h0);
    check("rstmid_wdata", 32'(wb_dout), 32'h0);
    check("rstmid_we", 32'(wb_we), 32'd0);
    check("rstmid_tx_data", 32'(tx_data), 32'h00);
    rst_n = 1'b1;
    stall_cfg = 0;
    cs_set(1'b0);
    check("rstmid_no_req", 32'(req_q.size()), 32'd0);

    // Bad command byte is ignored for the whole frame
    cs_set(1'b1);
    cyc_cnt = 0;
    send_byte(8'h40); send_byte(8'h00); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    repeat (3) @(negedge clk);
    check("bad_cmd_no_cyc", 32'(cyc_cnt), 32'd0);
    check("bad_cmd_no_req", 32'(req_q.size()), 32'd0);
    cs_set(1'b0);
    cs_set(1'b1);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h05); send_byte(8'hAB);
    wait_idle("recover");
    check_req("recover", 1'b1, 20'h00005, 8'hAB, 1'b1);
    cs_set(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
